phase_synthesizer: RTL and testbench

//  Resynthesis half of the pitch-correction path. Inverse of the frequency estimator.

---
 rtl/phase_synthesizer.sv | 141 ++++++++++++++
 tb/tb_phase_synthesizer.sv | 293 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/phase_synthesizer.sv
// Per-bin phase accumulator for resynthesis: phase[bin] += frequency * TWO_DT, wrapped to [-1, 1) half-turns.
// Optional product-overflow flag on port ovf when PHASE_SYNTH_OVF_EN is defined.
`timescale 1ns/1ps
module phase_synthesizer #(
   parameter int unsigned BIN_W  = 9,
   parameter logic [31:0] TWO_DT = 32'h0000_5F1C
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [31:0]      frequency,
   input  logic [BIN_W-1:0] bin,
   output logic             done,
   output logic [31:0]      phase
`ifdef PHASE_SYNTH_OVF_EN
   ,
   output logic             ovf
`endif
);
   localparam int unsigned NUM_BINS = 2**BIN_W;
   localparam logic        DT_NEG   = TWO_DT[31];
   localparam logic [31:0] DT_MAG   = DT_NEG ? (32'd0 - TWO_DT) : TWO_DT;

   typedef enum logic [1:0] {S_IDLE, S_MUL, S_ACC, S_WB} state_t;

   state_t              state_reg;
   logic [4:0]          count_reg;
   logic [63:0]         mcand_reg;
   logic [63:0]         prod_reg;
   logic [31:0]         mplier_reg;
   logic                neg_reg;
   logic [BIN_W-1:0]    bin_reg;
   logic [20:0]         sum_reg;
   logic                done_reg;
   logic [20:0]         phase_reg;
   logic [NUM_BINS-1:0] valid_reg;
   logic [NUM_BINS-1:0] wr_sel;
   logic [20:0]         rd_data_reg;

   // The wrap keeps only bits [20:0] of the 32-bit sum, so the whole
   // accumulate path is carried at 21 bits and sign-extended on output.
   logic [20:0]         table_mem [NUM_BINS];

   logic [31:0]         freq_mag;
   logic [20:0]         inc_mag;
   logic [20:0]         inc;
   logic [20:0]         base;

   always_comb begin
      freq_mag = frequency[31] ? (32'd0 - frequency) : frequency;
      inc_mag  = prod_reg[40:20];
      inc      = neg_reg ? (21'd0 - inc_mag) : inc_mag;
      base     = valid_reg[bin_reg] ? rd_data_reg : 21'd0;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg  <= S_IDLE;
         count_reg  <= '0;
         mcand_reg  <= '0;
         prod_reg   <= '0;
         mplier_reg <= '0;
         neg_reg    <= 1'b0;
         bin_reg    <= '0;
         sum_reg    <= '0;
         done_reg   <= 1'b1;
         phase_reg  <= '0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  mcand_reg  <= {32'd0, freq_mag};
                  mplier_reg <= DT_MAG;
                  prod_reg   <= '0;
                  count_reg  <= '0;
                  neg_reg    <= frequency[31] ^ DT_NEG;
                  bin_reg    <= bin;
                  done_reg   <= 1'b0;
                  state_reg  <= S_MUL;
               end
            end
            S_MUL: begin
               if (mplier_reg[0])
                  prod_reg <= prod_reg + mcand_reg;
               mcand_reg  <= {mcand_reg[62:0], 1'b0};
               mplier_reg <= {1'b0, mplier_reg[31:1]};
               count_reg  <= count_reg + 5'd1;
               if (count_reg == 5'd31)
                  state_reg <= S_ACC;
            end
            S_ACC: begin
               sum_reg   <= base + inc;
               state_reg <= S_WB;
            end
            S_WB: begin
               phase_reg <= sum_reg;
               done_reg  <= 1'b1;
               state_reg <= S_IDLE;
            end
            default: state_reg <= S_IDLE;
         endcase
      end
   end

   generate
      for (genvar gi = 0; gi < NUM_BINS; gi++) begin : g_sel
         assign wr_sel[gi] = (bin_reg == BIN_W'(gi));
      end
   endgenerate

   // Valid bits make the table read as zero after reset without clearing the RAM.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         valid_reg <= '0;
      else if (state_reg == S_WB)
         valid_reg <= valid_reg | wr_sel;
   end

   always_ff @(posedge clk) begin
      if (state_reg == S_WB)
         table_mem[bin_reg] <= sum_reg;
      rd_data_reg <= table_mem[bin_reg];
   end

`ifdef PHASE_SYNTH_OVF_EN
   logic ovf_reg;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         ovf_reg <= 1'b0;
      else if (state_reg == S_WB)
         ovf_reg <= |prod_reg[63:51];
   end

   assign ovf = ovf_reg;
`endif

   assign done  = done_reg;
   assign phase = {{11{phase_reg[20]}}, phase_reg};

endmodule

// File: tb/tb_phase_synthesizer.sv
// Scoreboard bench for phase_synthesizer: lockstep instances with different TWO_DT, checked against an arithmetic model.
`timescale 1ns/1ps
module tb_phase_synthesizer;
`ifdef PHASE_SYNTH_OVF_EN
   localparam int NDUT = 3;
`else
   localparam int NDUT = 2;
`endif
   localparam int BIN_W = 9;
   localparam int NB    = 512;
   localparam logic [31:0] DT_TAB [3] = '{32'h0008_0000, 32'h0000_5F1C, 32'h7FFF_FFFF};

   logic             clk = 1'b0;
   logic             rst_n = 1'b0;
   logic             start = 1'b0;
   logic [31:0]      frequency = '0;
   logic [BIN_W-1:0] bin = '0;
   logic [NDUT-1:0]  done_w;
   logic [31:0]      phase_w [NDUT];
`ifdef PHASE_SYNTH_OVF_EN
   logic [NDUT-1:0]  ovf_w;
`endif

   generate
      for (genvar gi = 0; gi < NDUT; gi++) begin : g_dut
         phase_synthesizer #(.BIN_W(BIN_W), .TWO_DT(DT_TAB[gi])) u_dut (
            .clk       (clk),
            .rst_n     (rst_n),
            .start     (start),
            .frequency (frequency),
            .bin       (bin),
            .done      (done_w[gi]),
            .phase     (phase_w[gi])
`ifdef PHASE_SYNTH_OVF_EN
            ,
            .ovf       (ovf_w[gi])
`endif
         );
      end
   endgenerate

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int txn    = 0;

   typedef struct packed {
      logic [NDUT-1:0][31:0] ph;
      logic [NDUT-1:0]       ov;
   } exp_t;

   exp_t        exp_q [$];
   logic [31:0] model_tab [NDUT][NB];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Reference: signed product scaled by 2^-20 with truncation toward zero, then phase mod 2.0 in [-1, 1).
   function automatic logic [31:0] wrap_phase(input logic [31:0] s);
      longint w;
      w = longint'({32'd0, s}) % 64'sd2097152;
      if (w >= 64'sd1048576)
         w = w - 64'sd2097152;
      return w[31:0];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < NDUT; i++)
         for (int j = 0; j < NB; j++)
            model_tab[i][j] = 32'd0;
   endtask

   task automatic push_model(input logic [31:0] f, input logic [BIN_W-1:0] b);
      exp_t   e;
      longint p, q, mag;
      logic [31:0] s;
      for (int i = 0; i < NDUT; i++) begin
         p   = longint'($signed(f)) * longint'($signed(DT_TAB[i]));
         q   = p / 64'sd1048576;
         s   = model_tab[i][b] + q[31:0];
         model_tab[i][b] = wrap_phase(s);
         e.ph[i] = model_tab[i][b];
         mag = (p < 0) ? -p : p;
         e.ov[i] = (mag >= (64'sd1 <<< 51));
      end
      exp_q.push_back(e);
   endtask

   // Monitor: pops one expectation at every done rising edge; phase must hold while busy.
   initial begin : monitor
      logic [NDUT-1:0] prev;
      logic [31:0]     last_ph [NDUT];
      exp_t            e;
      prev = '1;
      for (int i = 0; i < NDUT; i++) last_ph[i] = 32'd0;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            prev = '1;
            for (int i = 0; i < NDUT; i++) last_ph[i] = 32'd0;
            continue;
         end
         #1;
         if (!rst_n) continue;
         for (int i = 0; i < NDUT; i++)
            if (!done_w[i])
               chk($sformatf("hold_busy[%0d]", i), phase_w[i], last_ph[i]);
         if (!prev[0] && done_w[0]) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done actual=phase %h expected=no completion", phase_w[0]);
            end else begin
               e = exp_q.pop_front();
               txn++;
               $display("txn %0d: phase0=%h exp0=%h phase1=%h exp1=%h", txn,
                        phase_w[0], e.ph[0], phase_w[1], e.ph[1]);
               for (int i = 0; i < NDUT; i++) begin
                  chk($sformatf("done_sync[%0d]", i), {31'd0, done_w[i]}, 32'd1);
                  chk($sformatf("phase[%0d]", i), phase_w[i], e.ph[i]);
`ifdef PHASE_SYNTH_OVF_EN
                  chk($sformatf("ovf[%0d]", i), {31'd0, ovf_w[i]}, {31'd0, e.ov[i]});
`endif
                  last_ph[i] = e.ph[i];
               end
            end
         end
         prev = done_w;
      end
   end

   initial begin : watchdog
      #500000;
      $display("FAIL watchdog actual=still running expected=finished");
      $fatal(1, "watchdog expired");
   end

   task automatic wait_done(input string name);
      int n;
      n = 0;
      while (!done_w[0] && n < 50) begin
         @(posedge clk);
         #1;
         n++;
      end
      if (!done_w[0]) begin
         checks++;
         errors++;
         $display("FAIL %s_timeout actual=done 0 expected=done 1 within 50 cycles", name);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst_n = 1'b0;
      exp_q.delete();
      model_reset();
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
   endtask

   // One request; inputs are scrambled and a stray start pulse is thrown while busy.
   task automatic issue(input logic [31:0] f, input logic [BIN_W-1:0] b);
      wait_done("pre_issue");
      @(negedge clk);
      frequency = f;
      bin       = b;
      start     = 1'b1;
      push_model(f, b);
      @(negedge clk);
      start     = 1'b0;
      frequency = $urandom;
      bin       = BIN_W'($urandom);
      repeat ($urandom_range(3, 25)) @(negedge clk);
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      wait_done("issue");
   endtask

   task automatic seq_test1(input string tag);
      issue(32'h0010_0000, 9'd3);
      chk({tag, "_a"}, phase_w[0], 32'h0008_0000);
      issue(32'h0010_0000, 9'd3);
      chk({tag, "_b"}, phase_w[0], 32'hFFF0_0000);
      issue(32'h0010_0000, 9'd3);
      chk({tag, "_c"}, phase_w[0], 32'hFFF8_0000);
   endtask

   initial begin : stim
      logic [31:0] f;
      logic [BIN_W-1:0] b;
      model_reset();
      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      for (int i = 0; i < NDUT; i++) begin
         chk($sformatf("reset_done[%0d]", i), {31'd0, done_w[i]}, 32'd1);
         chk($sformatf("reset_phase[%0d]", i), phase_w[i], 32'd0);
      end

      seq_test1("t1");
      issue(32'hFFF0_0000, 9'd7);
      chk("t2_bin7", phase_w[0], 32'hFFF8_0000);
      issue(32'h0000_0000, 9'd3);
      chk("t2_bin3_unchanged", phase_w[0], 32'hFFF8_0000);

      do_reset();
      issue(32'h1B80_0000, 9'd0);
      chk("t4_440hz", phase_w[1], 32'h0003_7820);

      // Latency and ignored start while busy
      do_reset();
      @(negedge clk);
      frequency = 32'h0010_0000;
      bin       = 9'd5;
      start     = 1'b1;
      push_model(32'h0010_0000, 9'd5);
      @(posedge clk);
      #1;
      start = 1'b0;
      chk("t3_done_e0", {31'd0, done_w[0]}, 32'd0);
      for (int k = 1; k <= 34; k++) begin
         @(posedge clk);
         #1;
         if (k <= 33)
            chk($sformatf("t3_busy_e%0d", k), {31'd0, done_w[0]}, 32'd0);
         else
            chk("t3_done_e34", {31'd0, done_w[0]}, 32'd1);
         if (k == 9)  start = 1'b1;
         if (k == 10) start = 1'b0;
      end
      chk("t3_phase", phase_w[0], 32'h0008_0000);
      issue(32'h0000_0000, 9'd5);
      chk("t3_single_update", phase_w[0], 32'h0008_0000);

      // Reset during MUL
      issue(32'h0010_0000, 9'd3);
      @(negedge clk);
      frequency = 32'h0010_0000;
      bin       = 9'd3;
      start     = 1'b1;
      push_model(32'h0010_0000, 9'd3);
      @(posedge clk);
      #1;
      start = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      for (int i = 0; i < NDUT; i++) begin
         chk($sformatf("t5_done[%0d]", i), {31'd0, done_w[i]}, 32'd1);
         chk($sformatf("t5_phase[%0d]", i), phase_w[i], 32'd0);
      end
      exp_q.delete();
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      seq_test1("t5");

`ifdef PHASE_SYNTH_OVF_EN
      issue(32'h7FFF_FFFF, 9'd9);
      chk("t6_ovf_set", {31'd0, ovf_w[2]}, 32'd1);
      issue(32'h0010_0000, 9'd9);
      chk("t6_ovf_clr", {31'd0, ovf_w[2]}, 32'd0);
`endif

      for (int n = 0; n < 40; n++) begin
         case ($urandom_range(0, 2))
            0:       f = $urandom;
            1:       f = 32'($signed($urandom_range(0, 32'h01FF_FFFF)) - 32'sh0100_0000);
            default: f = {$urandom_range(0, 16383), 18'd0};
         endcase
         b = ($urandom_range(0, 9) == 0) ? 9'd511 : BIN_W'($urandom_range(0, 7));
         issue(f, b);
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
